// File: rtl/pad_pkg.sv
// pad_pkg: shared types and constants for the serial game-pad scanner.
//   pad_state_t   - scan FSM states
//   NES_* / SNES_* - bit index of each button inside one pad's slice of
//                    the buttons/pressed/released vectors
package pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_GAP    = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_CLK_LO = 3'd4,
        ST_DONE   = 3'd5
    } pad_state_t;

    localparam int NES_A      = 0;
    localparam int NES_B      = 1;
    localparam int NES_SELECT = 2;
    localparam int NES_START  = 3;
    localparam int NES_UP     = 4;
    localparam int NES_DOWN   = 5;
    localparam int NES_LEFT   = 6;
    localparam int NES_RIGHT  = 7;

    localparam int SNES_B      = 0;
    localparam int SNES_Y      = 1;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START  = 3;
    localparam int SNES_UP     = 4;
    localparam int SNES_DOWN   = 5;
    localparam int SNES_LEFT   = 6;
    localparam int SNES_RIGHT  = 7;
    localparam int SNES_A      = 8;
    localparam int SNES_X      = 9;
    localparam int SNES_L      = 10;
    localparam int SNES_R      = 11;

endpackage

// File: rtl/pad_tick_gen.sv
// pad_tick_gen: protocol half-period timer.
//   clk, reset_n - system clock, async active-low reset
//   clear        - force the count back to 0 (held while the scanner is idle)
//   enable       - advance the count
//   tick         - one-cycle pulse on count CLK_DIV-1, i.e. the last cycle
//                  of every half-period
module pad_tick_gen
    import pad_pkg::*;
#(
    parameter int CLK_DIV = 300
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
        end
    end

    assign tick = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/pad_scanner.sv
// pad_scanner: reads up to four 4021-style serial pads over one shared
// latch/clock pair and publishes held buttons plus edge strobes.
//   clk, reset_n - system clock, async active-low reset
//   start        - scan request, honoured only when idle
//   pad_data     - serial data per pad (low = pressed)
//   pad_latch    - shared latch, active-high
//   pad_clk      - shared shift clock, idle low
//   buttons      - held state, bit p*NUM_BITS+k = pad p button k (1 = pressed)
//   pressed      - buttons that went 0->1 in this scan (with valid)
//   released     - buttons that went 1->0 in this scan (with valid)
//   valid        - one-cycle strobe when a scan commits
//   busy         - high from LATCH entry through DONE
module pad_scanner
    import pad_pkg::*;
#(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 8,
    parameter int CLK_DIV     = 300,
    parameter int POLL_PERIOD = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic                         pad_latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] released,
    output logic                         valid,
    output logic                         busy
);

    localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int TW = NUM_PADS * NUM_BITS;
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

    pad_state_t    r_state;
    logic          r_half;
    logic [BW-1:0] r_bit;
    logic [TW-1:0] r_shift;
    logic          r_latch;
    logic          r_pclk;
    logic          r_busy;
    logic          r_valid;
    logic [TW-1:0] r_buttons;
    logic [TW-1:0] r_pressed;
    logic [TW-1:0] r_released;

    logic          w_tick;
    logic          w_poll_hit;
    logic          w_trigger;
    logic [TW-1:0] w_sample;

    // Counter held at zero while idle so LATCH always starts a fresh half-period.
    pad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (r_state == ST_IDLE),
        .enable  (r_state != ST_IDLE),
        .tick    (w_tick)
    );

    generate
        if (POLL_PERIOD != 0) begin : g_poll
            localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
            localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
            logic [PW-1:0] r_poll;

            // Free-running, independent of scan activity.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_poll <= '0;
                end else begin
                    r_poll <= (r_poll == POLL_LAST) ? '0 : r_poll + PW'(1);
                end
            end

            assign w_poll_hit = (r_poll == POLL_LAST);
        end else begin : g_no_poll
            assign w_poll_hit = 1'b0;
        end
    endgenerate

    assign w_trigger = start | w_poll_hit;

    // The last bit is sampled on the same edge that commits the scan, so the
    // committed vector splices the live pad lines into the top bit position.
    always_comb begin
        w_sample = r_shift;
        for (int p = 0; p < NUM_PADS; p++) begin
            w_sample[p*NUM_BITS + NUM_BITS - 1] = ~pad_data[p];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_half     <= 1'b0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_latch    <= 1'b0;
            r_pclk     <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_buttons  <= '0;
            r_pressed  <= '0;
            r_released <= '0;
        end else begin
            r_valid    <= 1'b0;
            r_pressed  <= '0;
            r_released <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_state <= ST_LATCH;
                        r_latch <= 1'b1;
                        r_busy  <= 1'b1;
                        r_half  <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    // Latch spans two half-periods.
                    if (w_tick) begin
                        if (r_half) begin
                            r_state <= ST_GAP;
                            r_latch <= 1'b0;
                        end else begin
                            r_half <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        for (int p = 0; p < NUM_PADS; p++) begin
                            r_shift[p*NUM_BITS] <= ~pad_data[p];
                        end
                        r_bit   <= BW'(1);
                        r_pclk  <= 1'b1;
                        r_state <= ST_CLK_HI;
                    end
                end
                ST_CLK_HI: begin
                    if (w_tick) begin
                        r_pclk  <= 1'b0;
                        r_state <= ST_CLK_LO;
                    end
                end
                ST_CLK_LO: begin
                    if (w_tick) begin
                        if (r_bit == LAST_BIT) begin
                            r_shift    <= w_sample;
                            r_buttons  <= w_sample;
                            r_pressed  <= w_sample & ~r_buttons;
                            r_released <= ~w_sample & r_buttons;
                            r_valid    <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            for (int p = 0; p < NUM_PADS; p++) begin
                                for (int k = 1; k < NUM_BITS; k++) begin
                                    if (BW'(k) == r_bit) begin
                                        r_shift[p*NUM_BITS + k] <= ~pad_data[p];
                                    end
                                end
                            end
                            r_bit   <= r_bit + BW'(1);
                            r_pclk  <= 1'b1;
                            r_state <= ST_CLK_HI;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_latch <= 1'b0;
                    r_pclk  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pad_latch = r_latch;
    assign pad_clk   = r_pclk;
    assign buttons   = r_buttons;
    assign pressed   = r_pressed;
    assign released  = r_released;
    assign valid     = r_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_pad_scanner.sv
// Bench for pad_scanner: an NES-style 2-pad instance (manual start) and an
// SNES-style 1-pad instance (auto-poll), each fed by a behavioural 4021 pad.
module tb_pad_scanner;

    localparam int DA = 4;
    localparam int NA = 8;
    localparam int DB = 2;
    localparam int NB = 16;
    localparam int POLLB = 100;
    localparam int LAT_A = 1 + (2*NA + 1)*DA;  // start step -> valid step
    localparam int SCAN_B = (2*NB + 1)*DB;     // trigger edge -> valid edge

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Instance A
    logic        reset_a = 1'b0;
    logic        start_a = 1'b0;
    logic [1:0]  pdata_a;
    logic        latch_a, pclk_a, valid_a, busy_a;
    logic [15:0] buttons_a, pressed_a, released_a;

    // Instance B
    logic        reset_b = 1'b0;
    logic        start_b = 1'b0;
    logic [0:0]  pdata_b;
    logic        latch_b, pclk_b, valid_b, busy_b;
    logic [15:0] buttons_b, pressed_b, released_b;

    pad_scanner #(.NUM_PADS(2), .NUM_BITS(NA), .CLK_DIV(DA), .POLL_PERIOD(0)) dut_a (
        .clk(clk), .reset_n(reset_a), .start(start_a), .pad_data(pdata_a),
        .pad_latch(latch_a), .pad_clk(pclk_a), .buttons(buttons_a),
        .pressed(pressed_a), .released(released_a), .valid(valid_a), .busy(busy_a)
    );

    pad_scanner #(.NUM_PADS(1), .NUM_BITS(NB), .CLK_DIV(DB), .POLL_PERIOD(POLLB)) dut_b (
        .clk(clk), .reset_n(reset_b), .start(start_b), .pad_data(pdata_b),
        .pad_latch(latch_b), .pad_clk(pclk_b), .buttons(buttons_b),
        .pressed(pressed_b), .released(released_b), .valid(valid_b), .busy(busy_b)
    );

    // Behavioural 4021 pads: parallel load while latch is high, shift on
    // pad_clk rising, serial-in tied high, output is register bit 0.
    logic [7:0]  btn0 = 8'h00, btn1 = 8'h00;
    logic [7:0]  sh0 = 8'hFF, sh1 = 8'hFF;
    logic        pclk_qa = 1'b0;
    logic [15:0] btn_b = 16'h0200;
    logic [15:0] sh_b = 16'hFFFF;
    logic        pclk_qb = 1'b0;

    always @(posedge clk) begin
        if (latch_a) begin
            sh0 <= ~btn0;
            sh1 <= ~btn1;
        end else if (pclk_a && !pclk_qa) begin
            sh0 <= {1'b1, sh0[7:1]};
            sh1 <= {1'b1, sh1[7:1]};
        end
        pclk_qa <= pclk_a;
        if (latch_b) begin
            sh_b <= ~btn_b;
        end else if (pclk_b && !pclk_qb) begin
            sh_b <= {1'b1, sh_b[15:1]};
        end
        pclk_qb <= pclk_b;
    end

    assign pdata_a = {sh1[0], sh0[0]};
    assign pdata_b = sh_b[0];

    // Reference state: what each instance last reported as held.
    logic [15:0] ref_a_old = 16'h0000;
    logic [15:0] ref_b_old = 16'h0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [51:0] va, vb;
        int bad;
        #1;
        va = {latch_a, pclk_a, buttons_a, pressed_a, released_a, valid_a, busy_a};
        vb = {latch_b, pclk_b, buttons_b, pressed_b, released_b, valid_b, busy_b};
        n_cmp++;
        if (va !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_a: got %h expected 0", va);
        end
        n_cmp++;
        if (vb !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_b: got %h expected 0", vb);
        end
        step();
        step();
        reset_a = 1'b1;
        reset_b = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (latch_a !== 1'b0 || pclk_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_single_scan();
        int lat_bad, pc_bad, vld_bad, bsy_bad, ovl, rises;
        logic prev_pc, le, pe, ve, be;
        logic [15:0] cb, cp, cr, exp;
        lat_bad = 0; pc_bad = 0; vld_bad = 0; bsy_bad = 0; ovl = 0; rises = 0;
        prev_pc = 1'b0; cb = 'x; cp = 'x; cr = 'x;
        btn0 = 8'h81;
        btn1 = 8'h00;
        start_a = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            step();
            start_a = 1'b0;
            le = (j >= 1 && j <= 2*DA);
            pe = (j >= 1 + 3*DA && j < LAT_A && ((j - 1 - 3*DA) % (2*DA)) < DA);
            ve = (j == LAT_A);
            be = (j >= 1 && j <= LAT_A);
            if (latch_a !== le) lat_bad++;
            if (pclk_a !== pe) pc_bad++;
            if (valid_a !== ve) vld_bad++;
            if (busy_a !== be) bsy_bad++;
            if (latch_a && pclk_a) ovl++;
            if (pclk_a && !prev_pc) rises++;
            prev_pc = pclk_a;
            if (valid_a === 1'b1) begin
                cb = buttons_a; cp = pressed_a; cr = released_a;
            end
        end
        n_cmp++;
        if (lat_bad != 0) begin n_fail++; $display("FAIL latch_window: %0d wrong cycles, expected 0", lat_bad); end
        n_cmp++;
        if (pc_bad != 0) begin n_fail++; $display("FAIL pad_clk_waveform: %0d wrong cycles, expected 0", pc_bad); end
        n_cmp++;
        if (rises != NA - 1) begin n_fail++; $display("FAIL pad_clk_pulses: got %0d expected %0d", rises, NA - 1); end
        n_cmp++;
        if (vld_bad != 0) begin n_fail++; $display("FAIL valid_timing: %0d wrong cycles, expected 0", vld_bad); end
        n_cmp++;
        if (bsy_bad != 0) begin n_fail++; $display("FAIL busy_window: %0d wrong cycles, expected 0", bsy_bad); end
        n_cmp++;
        if (ovl != 0) begin n_fail++; $display("FAIL latch_clk_overlap: %0d cycles, expected 0", ovl); end
        exp = {btn1, btn0};
        n_cmp++;
        if (cb !== exp) begin n_fail++; $display("FAIL first_buttons: got %h expected %h", cb, exp); end
        n_cmp++;
        if (cp !== (exp & ~ref_a_old)) begin n_fail++; $display("FAIL first_pressed: got %h expected %h", cp, exp & ~ref_a_old); end
        n_cmp++;
        if (cr !== (~exp & ref_a_old)) begin n_fail++; $display("FAIL first_released: got %h expected %h", cr, ~exp & ref_a_old); end
        ref_a_old = exp;
    endtask

    task automatic scan_a(input logic [7:0] b0, input logic [7:0] b1, input string name);
        int t;
        logic [15:0] exp;
        btn0 = b0;
        btn1 = b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        t = 1;
        while (valid_a !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        exp = {b1, b0};
        n_cmp++;
        if (t != LAT_A) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, t, LAT_A); end
        n_cmp++;
        if (buttons_a !== exp) begin n_fail++; $display("FAIL %s_buttons: got %h expected %h", name, buttons_a, exp); end
        n_cmp++;
        if (pressed_a !== (exp & ~ref_a_old)) begin n_fail++; $display("FAIL %s_pressed: got %h expected %h", name, pressed_a, exp & ~ref_a_old); end
        n_cmp++;
        if (released_a !== (~exp & ref_a_old)) begin n_fail++; $display("FAIL %s_released: got %h expected %h", name, released_a, ~exp & ref_a_old); end
        ref_a_old = exp;
        step();
        n_cmp++;
        if ({pressed_a, released_a, valid_a, busy_a} !== '0 || buttons_a !== exp) begin
            n_fail++;
            $display("FAIL %s_after: got p=%h r=%h v=%b busy=%b btn=%h expected p=0 r=0 v=0 busy=0 btn=%h",
                     name, pressed_a, released_a, valid_a, busy_a, buttons_a, exp);
        end
    endtask

    task automatic test_edges();
        scan_a(8'h10, 8'h00, "edge2");
        scan_a(8'h10, 8'h00, "edge3");
    endtask

    task automatic test_random_a();
        for (int i = 0; i < 6; i++) begin
            scan_a(8'($urandom), 8'($urandom), "rand_a");
        end
    endtask

    task automatic test_drop();
        int nv, at;
        nv = 0; at = -1;
        btn0 = 8'h24;
        btn1 = 8'h42;
        start_a = 1'b1;
        for (int j = 1; j <= 150; j++) begin
            step();
            start_a = (j == 10);
            if (valid_a === 1'b1) begin nv++; at = j; end
        end
        n_cmp++;
        if (nv != 1 || at != LAT_A) begin
            n_fail++;
            $display("FAIL drop_second_start: got %0d valids (last at %0d) expected 1 at %0d", nv, at, LAT_A);
        end
        ref_a_old = {btn1, btn0};
        n_cmp++;
        if (buttons_a !== ref_a_old) begin n_fail++; $display("FAIL drop_buttons: got %h expected %h", buttons_a, ref_a_old); end
    endtask

    task automatic test_reset_mid();
        int nv;
        logic [3:0] v;
        btn0 = 8'h5A;
        btn1 = 8'h03;
        start_a = 1'b1;
        // Fourth CLK_HI spans steps 1+3D+6D .. +D-1 = 37..40.
        for (int j = 1; j <= 38; j++) begin
            step();
            start_a = 1'b0;
        end
        n_cmp++;
        if (pclk_a !== 1'b1) begin n_fail++; $display("FAIL mid_in_clk_hi: pad_clk got %b expected 1", pclk_a); end
        reset_a = 1'b0;
        #1;
        v = {pclk_a, latch_a, busy_a, valid_a};
        n_cmp++;
        if (v !== 4'b0 || buttons_a !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got clk/latch/busy/valid=%b btn=%h expected 0000 0", v, buttons_a);
        end
        step();
        step();
        reset_a = 1'b1;
        ref_a_old = 16'h0000;
        nv = 0;
        for (int j = 0; j < 100; j++) begin
            step();
            if (valid_a !== 1'b0 || latch_a !== 1'b0) nv++;
        end
        n_cmp++;
        if (nv != 0) begin n_fail++; $display("FAIL mid_no_commit: %0d active cycles, expected 0", nv); end
        scan_a(8'h5A, 8'h03, "post_reset");
    endtask

    task automatic wait_valid_b(output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (valid_b !== 1'b1 && k < 300);
    endtask

    task automatic test_snes_poll();
        int k;
        logic [15:0] exp;
        wait_valid_b(k);
        n_cmp++;
        if (k >= 300) begin n_fail++; $display("FAIL snes_first_valid: none within %0d cycles", k); end
        n_cmp++;
        if (buttons_b !== 16'h0200) begin n_fail++; $display("FAIL snes_buttons_x: got %h expected 0200", buttons_b); end
        ref_b_old = 16'h0200;
        wait_valid_b(k);
        n_cmp++;
        if (k != POLLB) begin n_fail++; $display("FAIL snes_poll_interval: got %0d expected %0d", k, POLLB); end
        n_cmp++;
        if (buttons_b !== 16'h0200 || pressed_b !== 16'h0 || released_b !== 16'h0) begin
            n_fail++;
            $display("FAIL snes_repeat: got btn=%h p=%h r=%h expected 0200 0 0", buttons_b, pressed_b, released_b);
        end
        step();
        n_cmp++;
        if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL snes_busy_drop: got busy=%b valid=%b expected 0 0", busy_b, valid_b);
        end
        for (int i = 0; i < 4; i++) begin
            btn_b = {4'b0000, 12'($urandom)};
            wait_valid_b(k);
            exp = btn_b;
            n_cmp++;
            if (buttons_b !== exp || pressed_b !== (exp & ~ref_b_old) || released_b !== (~exp & ref_b_old)) begin
                n_fail++;
                $display("FAIL snes_rand: got btn=%h p=%h r=%h expected %h %h %h",
                         buttons_b, pressed_b, released_b, exp, exp & ~ref_b_old, ~exp & ref_b_old);
            end
            ref_b_old = exp;
        end
    endtask

    task automatic test_collision();
        int nv, at;
        // Now on a valid step S; the next poll trigger is sampled at edge
        // S + POLLB - SCAN_B, so hold start across that same edge.
        nv = 0; at = -1;
        for (int j = 1; j <= 199; j++) begin
            step();
            start_b = (j == POLLB - SCAN_B - 1);
            if (valid_b === 1'b1) begin nv++; at = j; end
        end
        start_b = 1'b0;
        n_cmp++;
        if (nv != 1 || at != POLLB) begin
            n_fail++;
            $display("FAIL poll_start_collision: got %0d valids (last at %0d) expected 1 at %0d", nv, at, POLLB);
        end
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_edges();
        test_random_a();
        test_drop();
        test_reset_mid();
        test_snes_poll();
        test_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
